prbs_link_sequencer: RTL
========================

# prbs_link_sequencer

Controller that sequences one high-speed link pattern test. It holds the pattern generator and pattern checker in reset until the lane is ready. It then releases the generator, waits a settle time, releases the checker, and waits for checker lock. Finally it runs a test window of programmable length, counts errors, and reports pass/fail. It drives the active-low generator/checker enables consumed by the startup delay logic and sits between the test-control registers and the pattern datapath.

## Interface
- SETTLE_CYCLES, 16, cycles the generator runs before the checker is released (≥1)
- LOCK_TIMEOUT, 1024, maximum cycles spent waiting for checker lock (≥1)
- ERR_CNT_W, 16, error counter width
- tx_clk_i  in  1  link transmit clock; the only clock
- reset_n_i  in  1  asynchronous, active-low reset
- start_i  in  1  level request; starts a test from IDLE
- abort_i  in  1  synchronous abort; returns to IDLE
- lane_ready_i  in  1  transceiver lane ready (synchronous to tx_clk_i)
- run_cycles_i  in  32  test window length; sampled on leaving IDLE
- chk_lock_i  in  1  checker aligned to the pattern
- chk_err_i  in  1  per-cycle checker error strobe
- pattern_gen_n_o  out  1  generator reset/enable, active-low
- pattern_chk_n_o  out  1  checker reset/enable, active-low
- busy_o  out  1  high in every state except IDLE and DONE
- done_o  out  1  high in DONE
- pass_o  out  1  result; valid while done_o=1
- timeout_o  out  1  lock timeout occurred (valid in DONE)
- link_lost_o  out  1  lane_ready_i dropped during the test (valid in DONE)
- err_count_o  out  ERR_CNT_W  saturating error count
- state_o  out  3  current state encoding

## Operation
- States and their outputs (all outputs are registered Moore outputs):
  - IDLE=0: gen_n=0, chk_n=0.
  - WAIT_READY=1: gen_n=0, chk_n=0.
  - GEN_START=2: gen_n=1, chk_n=0.
  - WAIT_LOCK=3: gen_n=1, chk_n=1.
  - RUN=4: gen_n=1, chk_n=1.
  - DONE=5: gen_n=0, chk_n=0.
  - Codes 6 and 7 are unreachable and recover to IDLE.
- IDLE, start_i=1:
  - Go to WAIT_READY.
  - Latch run_cycles_i; a value of 0 is treated as 1.
  - Clear err_count, pass, timeout and link_lost.
- WAIT_READY, lane_ready_i=1: go to GEN_START. There is no timeout in this state.
- GEN_START: stay exactly SETTLE_CYCLES cycles, then go to WAIT_LOCK.
- WAIT_LOCK:
  - chk_lock_i=1 → RUN.
  - If no lock is seen within LOCK_TIMEOUT cycles → DONE with timeout=1.
  - Lock and the timeout expiring in the same cycle: lock wins.
- RUN:
  - Stay exactly the latched number of cycles, then go to DONE.
  - Each RUN cycle with chk_err_i=1 or chk_lock_i=0 adds 1 to err_count.
  - err_count saturates at 2^ERR_CNT_W−1.
- DONE:
  - pass = (err_count==0) & ~timeout & ~link_lost, set on entry.
  - Stay while start_i=1; go to IDLE when start_i=0. A new test therefore needs start_i to be deasserted and reasserted.
  - Results (done/pass/flags/count) hold until the next start. The counts remain readable in IDLE; only done_o drops.
- lane_ready_i=0 in GEN_START, WAIT_LOCK or RUN → DONE with link_lost=1, pass=0.
- abort_i=1 in any non-IDLE state → IDLE. Clears err_count, pass, timeout and link_lost.
- Per-cycle priority: reset > abort_i > lane loss > timeout/lock/window end.

## Timing
- Reset values: state=IDLE.
  - pattern_gen_n_o=0, pattern_chk_n_o=0.
  - busy_o=0, done_o=0, pass_o=0, timeout_o=0, link_lost_o=0.
  - err_count_o=0, state_o=0.
- start_i sampled high at edge n (lane ready) produces:
  - state_o=1 after edge n.
  - pattern_gen_n_o=1 after edge n+1.
  - pattern_chk_n_o=1 after edge n+1+SETTLE_CYCLES.
- Lock sampled high at edge m in WAIT_LOCK: RUN is visible after edge m. RUN lasts N cycles, then DONE.
- An error sampled at edge k is reflected in err_count_o after edge k. An error in the final RUN cycle is counted and included in pass_o.
- abort_i or lane loss takes effect on the next edge; the enables go low one cycle after the sampling edge.
- Asynchronous reset mid-test forces both enables low immediately.

## Test plan
- Nominal (SETTLE_CYCLES=16, run_cycles_i=100, lock 5 cycles after chk release, no errors):
  - pattern_chk_n_o rises 16 cycles after pattern_gen_n_o.
  - RUN lasts 100 cycles; done_o=1, pass_o=1, err_count_o=0.
- Errors: pulse chk_err_i on 3 RUN cycles, including the last one, and drop chk_lock_i for 2 cycles → err_count_o=5, pass_o=0.
- Timeout (LOCK_TIMEOUT=8, chk_lock_i held 0): DONE after 8 WAIT_LOCK cycles; timeout_o=1, pass_o=0, enables low.
- Lock coincident with the final timeout cycle → RUN entered, timeout_o=0.
- Lane loss: lane_ready_i low in RUN cycle 10 → DONE next cycle, link_lost_o=1, pass_o=0.
- Control corners:
  - abort_i in RUN → IDLE, err_count_o=0, done_o=0.
  - run_cycles_i=0 → RUN lasts 1 cycle.
  - Holding start_i in DONE does not restart; a 0→1 toggle does.
  - ERR_CNT_W=4 with 20 errors → err_count_o=15.

Source files
------------

// File: rtl/prbs_link_sequencer_if.sv
// Control/status bundle between the test-control registers, the pattern
// datapath and the link pattern-test sequencer.
interface prbs_link_sequencer_if #(
  parameter int unsigned ERR_CNT_W = 16
);
  logic                 start_i;
  logic                 abort_i;
  logic                 lane_ready_i;
  logic [31:0]          run_cycles_i;
  logic                 chk_lock_i;
  logic                 chk_err_i;
  logic                 pattern_gen_n_o;
  logic                 pattern_chk_n_o;
  logic                 busy_o;
  logic                 done_o;
  logic                 pass_o;
  logic                 timeout_o;
  logic                 link_lost_o;
  logic [ERR_CNT_W-1:0] err_count_o;
  logic [2:0]           state_o;

  modport slave (
    input  start_i, abort_i, lane_ready_i, run_cycles_i, chk_lock_i, chk_err_i,
    output pattern_gen_n_o, pattern_chk_n_o, busy_o, done_o, pass_o,
           timeout_o, link_lost_o, err_count_o, state_o
  );

  modport master (
    output start_i, abort_i, lane_ready_i, run_cycles_i, chk_lock_i, chk_err_i,
    input  pattern_gen_n_o, pattern_chk_n_o, busy_o, done_o, pass_o,
           timeout_o, link_lost_o, err_count_o, state_o
  );
endinterface

// File: rtl/prbs_link_sequencer.sv
// Sequences one link pattern test: generator release, settle, checker
// release, lock wait, timed run window with error counting, pass/fail.
//
// state       | meaning
// IDLE   (0)  | both pattern blocks held in reset, results readable
// WAIT_READY  | waiting for lane_ready_i, no timeout
// GEN_START   | generator running for SETTLE_CYCLES
// WAIT_LOCK   | checker released, waiting up to LOCK_TIMEOUT for lock
// RUN    (4)  | test window, counting checker errors
// DONE   (5)  | result held until start_i is released
module prbs_link_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT  = 1024,
  parameter int unsigned ERR_CNT_W     = 16
) (
  input logic                  tx_clk_i,
  input logic                  reset_n_i,
  prbs_link_sequencer_if.slave link_if
);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_GEN_START  = 3'd2,
    ST_WAIT_LOCK  = 3'd3,
    ST_RUN        = 3'd4,
    ST_DONE       = 3'd5
  } state_e;

  localparam logic [31:0]          SETTLE_LOAD = SETTLE_CYCLES - 1;
  localparam logic [31:0]          LOCK_LOAD   = LOCK_TIMEOUT - 1;
  localparam logic [ERR_CNT_W-1:0] ERR_MAX     = '1;

  state_e               state_q, state_d;
  logic [31:0]          cnt_q, cnt_d;
  logic [31:0]          run_len_q, run_len_d;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic                 pass_q, pass_d;
  logic                 timeout_q, timeout_d;
  logic                 link_lost_q, link_lost_d;
  logic                 gen_n_q, gen_n_d;
  logic                 chk_n_q, chk_n_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 run_err;
  logic                 lane_lost;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_len_d   = run_len_q;
    err_cnt_d   = err_cnt_q;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    link_lost_d = link_lost_q;
    run_err     = link_if.chk_err_i | ~link_if.chk_lock_i;
    lane_lost   = ~link_if.lane_ready_i;

    if (link_if.abort_i && (state_q != ST_IDLE)) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      err_cnt_d   = '0;
      pass_d      = 1'b0;
      timeout_d   = 1'b0;
      link_lost_d = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (link_if.start_i) begin
            state_d     = ST_WAIT_READY;
            run_len_d   = (link_if.run_cycles_i == 32'd0) ? 32'd1 : link_if.run_cycles_i;
            err_cnt_d   = '0;
            pass_d      = 1'b0;
            timeout_d   = 1'b0;
            link_lost_d = 1'b0;
          end
        end
        ST_WAIT_READY: begin
          if (link_if.lane_ready_i) begin
            state_d = ST_GEN_START;
            cnt_d   = SETTLE_LOAD;
          end
        end
        ST_GEN_START: begin
          if (lane_lost) begin
            state_d     = ST_DONE;
            link_lost_d = 1'b1;
            pass_d      = 1'b0;
          end else if (cnt_q == 32'd0) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = LOCK_LOAD;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_WAIT_LOCK: begin
          // Lock is checked ahead of expiry so a last-cycle lock still runs.
          if (lane_lost) begin
            state_d     = ST_DONE;
            link_lost_d = 1'b1;
            pass_d      = 1'b0;
          end else if (link_if.chk_lock_i) begin
            state_d = ST_RUN;
            cnt_d   = run_len_q - 32'd1;
          end else if (cnt_q == 32'd0) begin
            state_d   = ST_DONE;
            timeout_d = 1'b1;
            pass_d    = 1'b0;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_RUN: begin
          if (run_err && (err_cnt_q != ERR_MAX)) begin
            err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
          end
          if (lane_lost) begin
            state_d     = ST_DONE;
            link_lost_d = 1'b1;
            pass_d      = 1'b0;
          end else if (cnt_q == 32'd0) begin
            state_d = ST_DONE;
            pass_d  = (err_cnt_d == '0) & ~timeout_q & ~link_lost_q;
          end else begin
            cnt_d = cnt_q - 32'd1;
          end
        end
        ST_DONE: begin
          if (!link_if.start_i) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    gen_n_d = (state_d == ST_GEN_START) || (state_d == ST_WAIT_LOCK) || (state_d == ST_RUN);
    chk_n_d = (state_d == ST_WAIT_LOCK) || (state_d == ST_RUN);
    busy_d  = (state_d != ST_IDLE) && (state_d != ST_DONE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge tx_clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      run_len_q   <= 32'd1;
      err_cnt_q   <= '0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      link_lost_q <= 1'b0;
      gen_n_q     <= 1'b0;
      chk_n_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      run_len_q   <= run_len_d;
      err_cnt_q   <= err_cnt_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      link_lost_q <= link_lost_d;
      gen_n_q     <= gen_n_d;
      chk_n_q     <= chk_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign link_if.pattern_gen_n_o = gen_n_q;
  assign link_if.pattern_chk_n_o = chk_n_q;
  assign link_if.busy_o          = busy_q;
  assign link_if.done_o          = done_q;
  assign link_if.pass_o          = pass_q;
  assign link_if.timeout_o       = timeout_q;
  assign link_if.link_lost_o     = link_lost_q;
  assign link_if.err_count_o     = err_cnt_q;
  assign link_if.state_o         = state_q;

endmodule
